viterbi_traceback: RTL and testbench
====================================

Name: viterbi_traceback

Overview:
- Downstream consumer of the two-state butterfly survivor stage. Each cycle it can accept that stage's pair of survivor metrics and 4-bit decision codes.
- Buffers decision codes for one frame of up to DEPTH stages. At frame end it picks the better final state, then traces back through the stored codes.
- Emits one decision code per stage, in reverse time order (LIFO), over a valid/ready handshake.
- Feeds the bit-unpacking/reorder stage of the decoder.

Parameters:
- DEPTH, 8, maximum stages per frame and decision buffer entries (power of 2, >=2).
- PTR_W, 3, pointer width, equal to log2(DEPTH).

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- in_valid  input  1  upstream stage result valid
- in_ready  output  1  block can accept a stage
- in_last  input  1  final stage of frame, qualified by in_valid
- survivor_10  input  8  unsigned path metric, state 10
- survivor_01  input  8  unsigned path metric, state 01
- temp_c10  input  4  decision code, state 10
- temp_c01  input  4  decision code, state 01
- out_valid  output  1  out_code valid
- out_ready  input  1  downstream accepts out_code
- out_code  output  4  traced decision code for current stage
- out_state  output  1  traced state for current stage (1 = state 10, 0 = state 01)
- out_last  output  1  marks stage 0 (oldest) of frame
- frame_trunc  output  1  sticky flag: a frame hit DEPTH without in_last

Behaviour:
- Reset (RST_N low, async): FSM to FILL, pointers and count to 0, traced state to 1. in_ready=1 after reset deassertion; out_valid=0, out_code=0, out_state=0, out_last=0, frame_trunc=0. Buffer contents are don't-care.
- Reset mid-frame or mid-trace: the frame is abandoned and no further outputs are produced for it.
- FSM states:
  - FILL: in_ready=1. Accept when in_valid && in_ready. Write {temp_c10,temp_c01} to mem[wr_ptr]. Register survivor_10/survivor_01 into last_m10/last_m01. Increment wr_ptr.
  - FILL exit: go to SELECT when the accepted beat has in_last=1, or when the accepted beat makes count==DEPTH. The count==DEPTH case sets frame_trunc; the beat is treated as last.
  - SELECT (1 cycle): in_ready=0. State = 1 (state 10) if last_m10 <= last_m01 (unsigned), else 0. Ties go to state 10. rd_ptr = count-1. Then go to TRACE.
  - TRACE: in_ready=0, out_valid=1.
    - out_code = mem[rd_ptr] half selected by state: upper nibble (c10) if state=1, lower nibble (c01) if state=0.
    - out_state = state; out_last = (rd_ptr==0).
    - On out_valid && out_ready: predecessor state = (out_code[3:2]==2'b10) ? 1 : 0, then decrement rd_ptr.
    - After the handshake with out_last=1: go to FILL, clear count and wr_ptr, drop out_valid on the next cycle.
- Output stability: out_code, out_state and out_last hold stable while out_valid && !out_ready.
- Latency: out_valid rises on the 2nd rising edge after the final input handshake. Stages then stream at one per cycle while out_ready=1.
- Back-pressure: no input is accepted during SELECT or TRACE, and upstream must hold. A frame of N stages takes N+1 cycles minimum between in_last and returning to FILL.
- Single-stage frame (in_last on first beat): one output with out_last=1.
- in_last coinciding with count reaching DEPTH: treated as normal last; frame_trunc is not set.
- frame_trunc clears only on reset.
- Metrics are used only for the final-state choice; no arithmetic on metrics beyond one unsigned compare.

Test Plan:
- Reset: hold RST_N low mid-TRACE -> out_valid=0, in_ready=1 one cycle after release, frame_trunc=0.
- 3-stage frame: codes (c10,c01) = (1001,0101), (0110,1010), (1001,0101); final metrics s10=0x20, s01=0x30 -> start state 10. With out_ready=1 the outputs are out_code 1001, 0110, 0101 and out_state 1, 1, 0, out_last only on the third. First out_valid arrives 2 cycles after in_last.
- Tie: same frame with s10=s01=0x40 -> start state 10, identical output sequence.
- Back-pressure: out_ready low for 3 cycles on the 2nd output -> 0110 held stable, in_ready stays 0, sequence unchanged.
- Truncation: 8 beats without in_last (DEPTH=8) -> frame_trunc=1, 8 outputs emitted, out_last on the 8th. A following frame is accepted and frame_trunc stays 1.
- Single stage: one beat with in_last, c10=0110, c01=1010, s10=0x50, s01=0x10 -> single output 1010, out_state=0, out_last=1, then in_ready=1.

Source files
------------

// File: rtl/viterbi_traceback.sv
// ============================================================================
//  Module   : viterbi_traceback
//  Purpose  : Buffers one frame of two-state survivor decision codes, selects
//             the better final state and traces back, emitting codes LIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module viterbi_traceback #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_last,
    input  logic [7:0] survivor_10,
    input  logic [7:0] survivor_01,
    input  logic [3:0] temp_c10,
    input  logic [3:0] temp_c01,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_code,
    output logic       out_state,
    output logic       out_last,
    output logic       frame_trunc
);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_SELECT = 2'd1,
        S_TRACE  = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       last_m10_q, last_m10_d;
    logic [7:0]       last_m01_q, last_m01_d;
    logic             tstate_q, tstate_d;
    logic             trunc_q, trunc_d;

    // Each entry packs {c10, c01}; contents need no reset.
    logic [7:0]       mem_q [DEPTH];

    logic             w_accept;
    logic [PTR_W:0]   w_count_inc;
    logic [PTR_W:0]   w_count_dec;
    logic             w_full;
    logic [7:0]       w_rd_word;
    logic [3:0]       w_code;
    logic             w_at_oldest;
    logic             w_tracing;

    assign w_accept    = in_valid && (state_q == S_FILL);
    assign w_count_inc = count_q + 1'b1;
    assign w_count_dec = count_q - 1'b1;
    assign w_full      = (w_count_inc == FULL_COUNT);
    assign w_rd_word   = mem_q[rd_ptr_q];
    assign w_code      = tstate_q ? w_rd_word[7:4] : w_rd_word[3:0];
    assign w_at_oldest = (rd_ptr_q == '0);
    assign w_tracing   = (state_q == S_TRACE);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_m10_d = last_m10_q;
        last_m01_d = last_m01_q;
        tstate_d   = tstate_q;
        trunc_d    = trunc_q;
        case (state_q)
            S_FILL: begin
                if (w_accept) begin
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    count_d    = w_count_inc;
                    last_m10_d = survivor_10;
                    last_m01_d = survivor_01;
                    if (in_last || w_full) begin
                        state_d = S_SELECT;
                    end
                    // A buffer-full beat without in_last is forced to end the frame.
                    if (w_full && !in_last) begin
                        trunc_d = 1'b1;
                    end
                end
            end
            S_SELECT: begin
                tstate_d = (last_m10_q <= last_m01_q);
                rd_ptr_d = w_count_dec[PTR_W-1:0];
                state_d  = S_TRACE;
            end
            S_TRACE: begin
                if (out_ready) begin
                    tstate_d = (w_code[3:2] == 2'b10);
                    rd_ptr_d = rd_ptr_q - 1'b1;
                    if (w_at_oldest) begin
                        state_d  = S_FILL;
                        count_d  = '0;
                        wr_ptr_d = '0;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_m10_q <= '0;
            last_m01_q <= '0;
            tstate_q   <= 1'b1;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_m10_q <= last_m10_d;
            last_m01_q <= last_m01_d;
            tstate_q   <= tstate_d;
            trunc_q    <= trunc_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= {temp_c10, temp_c01};
        end
    end

    assign in_ready    = (state_q == S_FILL);
    assign out_valid   = w_tracing;
    assign out_code    = w_tracing ? w_code : 4'd0;
    assign out_state   = w_tracing && tstate_q;
    assign out_last    = w_tracing && w_at_oldest;
    assign frame_trunc = trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_traceback.sv
// ============================================================================
//  Module   : tb_viterbi_traceback
//  Purpose  : Directed and randomized frames checked against a queue-based
//             traceback reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_viterbi_traceback;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic       CLK;
    logic       RST_N;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [7:0] survivor_10;
    logic [7:0] survivor_01;
    logic [3:0] temp_c10;
    logic [3:0] temp_c01;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_code;
    logic       out_state;
    logic       out_last;
    logic       frame_trunc;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [3:0] f_c10[$];
    logic [3:0] f_c01[$];
    logic [7:0] f_m10;
    logic [7:0] f_m01;
    logic [3:0] e_code[$];
    logic       e_state[$];
    logic       exp_trunc;

    viterbi_traceback #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .survivor_10 (survivor_10),
        .survivor_01 (survivor_01),
        .temp_c10    (temp_c10),
        .temp_c01    (temp_c01),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_state   (out_state),
        .out_last    (out_last),
        .frame_trunc (frame_trunc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: start in the lower-metric state (ties to state 10), walk the
    // stored stages newest to oldest, following the predecessor encoded in
    // the top two bits of each chosen code.
    task automatic build_model();
        logic       st;
        logic [3:0] code;
        e_code.delete();
        e_state.delete();
        st = (f_m10 <= f_m01);
        for (int k = f_c10.size() - 1; k >= 0; k--) begin
            code = st ? f_c10[k] : f_c01[k];
            e_code.push_back(code);
            e_state.push_back(st);
            st = (code[3:2] == 2'b10);
        end
    endtask

    task automatic send_beat(input logic [3:0] c10, input logic [3:0] c01,
                             input logic [7:0] m10, input logic [7:0] m01, input logic last);
        int w;
        in_valid    = 1'b1;
        in_last     = last;
        temp_c10    = c10;
        temp_c01    = c01;
        survivor_10 = m10;
        survivor_01 = m01;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        if (w >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic send_last);
        int n;
        n = f_c10.size();
        for (int i = 0; i < n; i++) begin
            send_beat(f_c10[i], f_c01[i],
                      (i == n - 1) ? f_m10 : 8'($urandom),
                      (i == n - 1) ? f_m01 : 8'($urandom),
                      send_last && (i == n - 1));
        end
        if (!send_last) exp_trunc = 1'b1;
    endtask

    task automatic run_frame(input logic send_last, input int stall_idx,
                             input int stall_len, input logic chk_lat);
        int n;
        int idx;
        int cyc;
        int stalled;
        int first_cyc;
        n = f_c10.size();
        build_model();
        out_ready = 1'b1;
        send_frame(send_last);
        if (chk_lat) begin
            check("lat_valid_low", 32'(out_valid), 32'd0);
            check("lat_in_ready_low", 32'(in_ready), 32'd0);
        end
        idx = 0;
        cyc = 0;
        stalled = 0;
        first_cyc = -1;
        while (idx < n && cyc < 200) begin
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (idx == stall_idx && stalled < stall_len) begin
                    out_ready = 1'b0;
                    check("stall_code", 32'(out_code), 32'(e_code[idx]));
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    check("out_code", 32'(out_code), 32'(e_code[idx]));
                    check("out_state", 32'(out_state), 32'(e_state[idx]));
                    check("out_last", 32'(out_last), 32'(idx == n - 1));
                    idx++;
                end
            end
            @(posedge CLK); #1;
            cyc++;
        end
        if (idx < n) check("out_timeout", 32'(idx), 32'(n));
        if (chk_lat) check("lat_first_valid", 32'(first_cyc), 32'd1);
        out_ready = 1'b1;
        check("end_valid_low", 32'(out_valid), 32'd0);
        check("end_in_ready", 32'(in_ready), 32'd1);
        check("frame_trunc", 32'(frame_trunc), 32'(exp_trunc));
    endtask

    task automatic load_three(input logic [7:0] m10, input logic [7:0] m01);
        f_c10 = '{4'b1001, 4'b0110, 4'b1001};
        f_c01 = '{4'b0101, 4'b1010, 4'b0101};
        f_m10 = m10;
        f_m01 = m01;
    endtask

    task automatic load_random(input int n);
        f_c10.delete();
        f_c01.delete();
        for (int i = 0; i < n; i++) begin
            f_c10.push_back(4'($urandom));
            f_c01.push_back(4'($urandom));
        end
        f_m10 = 8'($urandom);
        f_m01 = ($urandom_range(0, 3) == 0) ? f_m10 : 8'($urandom);
    endtask

    initial begin
        RST_N       = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        survivor_10 = 8'd0;
        survivor_01 = 8'd0;
        temp_c10    = 4'd0;
        temp_c01    = 4'd0;
        out_ready   = 1'b1;
        exp_trunc   = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_out_state", 32'(out_state), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_trunc", 32'(frame_trunc), 32'd0);

        // Three-stage frame, start state 10, with latency check.
        load_three(8'h20, 8'h30);
        run_frame(1'b1, -1, 0, 1'b1);
        check("model_three_code0", 32'(e_code[0]), 32'b1001);

        // Metric tie resolves to state 10.
        load_three(8'h40, 8'h40);
        run_frame(1'b1, -1, 0, 1'b1);

        // Back-pressure on the second output.
        load_three(8'h20, 8'h30);
        run_frame(1'b1, 1, 3, 1'b0);

        // Single-stage frame ending in state 01.
        f_c10 = '{4'b0110};
        f_c01 = '{4'b1010};
        f_m10 = 8'h50;
        f_m01 = 8'h10;
        run_frame(1'b1, -1, 0, 1'b1);

        // Full buffer with in_last on the final beat is not a truncation.
        load_random(DEPTH);
        run_frame(1'b1, 2, 2, 1'b1);

        for (int r = 0; r < 10; r++) begin
            load_random(int'($urandom_range(1, DEPTH)));
            run_frame(1'b1, int'($urandom_range(0, DEPTH)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Truncated frame, then a normal frame with the flag still set.
        load_random(DEPTH);
        run_frame(1'b0, -1, 0, 1'b1);
        load_random(3);
        run_frame(1'b1, -1, 0, 1'b0);

        // Reset in the middle of a trace abandons the frame.
        load_random(5);
        out_ready = 1'b0;
        send_frame(1'b1);
        repeat (3) @(posedge CLK);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        RST_N = 1'b0;
        #2;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_code", 32'(out_code), 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        out_ready = 1'b1;
        exp_trunc = 1'b0;
        @(posedge CLK); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_trunc", 32'(frame_trunc), 32'd0);

        load_random(4);
        run_frame(1'b1, 0, 1, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
